// File: rtl/miriscv_lsu_if.sv
// Data-memory bus between the load/store unit and the memory.
// The LSU is the master; the memory (or bench responder) is the slave.
interface miriscv_lsu_if;
   logic        data_req_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;

   modport master (
      output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
      input  data_gnt_i, data_rvalid_i, data_rdata_i
   );

   modport slave (
      input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
      output data_gnt_i, data_rvalid_i, data_rdata_i
   );
endinterface

// File: rtl/miriscv_lsu.sv
// Load/store unit: aligns core accesses onto a 32-bit word bus and
// extracts/extends load data. One transaction at a time, stalling the core.
module miriscv_lsu (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             lsu_req_i,
   input  logic             lsu_we_i,
   input  logic [2:0]       lsu_size_i,
   input  logic [31:0]      lsu_addr_i,
   input  logic [31:0]      lsu_data_i,
   output logic [31:0]      lsu_data_o,
   output logic             lsu_stall_req_o,
   output logic             lsu_err_o,
   miriscv_lsu_if.master    data_bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state_reg, state_next;
   logic [31:0] addr_reg, addr_next;
   logic [3:0]  be_reg, be_next;
   logic [31:0] wdata_reg, wdata_next;
   logic        we_reg, we_next;
   logic [2:0]  size_reg, size_next;
   logic [1:0]  offset_reg, offset_next;
   logic        err_reg, err_next;
   logic [31:0] rdata_reg, rdata_next;

   logic        access_legal;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [31:0] lane;
   logic [31:0] load_ext;

   // Legality: natural alignment per size, valid funct3, unsigned sizes only for loads
   always_comb begin
      access_legal = 1'b0;
      case (lsu_size_i)
         3'b000, 3'b100: access_legal = 1'b1;
         3'b001, 3'b101: access_legal = ~lsu_addr_i[0];
         3'b010:         access_legal = (lsu_addr_i[1:0] == 2'b00);
         default:        access_legal = 1'b0;
      endcase
      if (lsu_we_i && lsu_size_i[2])
         access_legal = 1'b0;
   end

   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = lsu_data_i;
      case (lsu_size_i[1:0])
         2'b00: begin
            be_calc    = 4'b0001 << lsu_addr_i[1:0];
            wdata_calc = {4{lsu_data_i[7:0]}};
         end
         2'b01: begin
            be_calc    = 4'b0011 << lsu_addr_i[1:0];
            wdata_calc = {2{lsu_data_i[15:0]}};
         end
         default: begin
            be_calc    = 4'b1111;
            wdata_calc = lsu_data_i;
         end
      endcase
   end

   // Move the addressed lane down to bit 0, then extend by access size
   always_comb begin
      lane     = data_bus.data_rdata_i >> {offset_reg, 3'b000};
      load_ext = data_bus.data_rdata_i;
      case (size_reg)
         3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_ext = {24'h0, lane[7:0]};
         3'b101:  load_ext = {16'h0, lane[15:0]};
         default: load_ext = data_bus.data_rdata_i;
      endcase
   end

   always_comb begin
      state_next  = state_reg;
      addr_next   = addr_reg;
      be_next     = be_reg;
      wdata_next  = wdata_reg;
      we_next     = we_reg;
      size_next   = size_reg;
      offset_next = offset_reg;
      err_next    = err_reg;
      rdata_next  = rdata_reg;
      case (state_reg)
         IDLE: begin
            if (lsu_req_i) begin
               if (access_legal) begin
                  state_next  = REQ;
                  addr_next   = {lsu_addr_i[31:2], 2'b00};
                  be_next     = be_calc;
                  wdata_next  = wdata_calc;
                  we_next     = lsu_we_i;
                  size_next   = lsu_size_i;
                  offset_next = lsu_addr_i[1:0];
               end else begin
                  state_next = DONE;
                  err_next   = 1'b1;
               end
            end
         end
         REQ: begin
            if (data_bus.data_gnt_i)
               state_next = we_reg ? DONE : WAIT;
         end
         WAIT: begin
            if (data_bus.data_rvalid_i) begin
               state_next = DONE;
               rdata_next = load_ext;
            end
         end
         DONE: begin
            state_next = IDLE;
            err_next   = 1'b0;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg  <= IDLE;
         addr_reg   <= 32'h0;
         be_reg     <= 4'h0;
         wdata_reg  <= 32'h0;
         we_reg     <= 1'b0;
         size_reg   <= 3'b000;
         offset_reg <= 2'b00;
         err_reg    <= 1'b0;
         rdata_reg  <= 32'h0;
      end else begin
         state_reg  <= state_next;
         addr_reg   <= addr_next;
         be_reg     <= be_next;
         wdata_reg  <= wdata_next;
         we_reg     <= we_next;
         size_reg   <= size_next;
         offset_reg <= offset_next;
         err_reg    <= err_next;
         rdata_reg  <= rdata_next;
      end
   end

   assign data_bus.data_req_o   = (state_reg == REQ);
   assign data_bus.data_we_o    = we_reg;
   assign data_bus.data_be_o    = be_reg;
   assign data_bus.data_addr_o  = addr_reg;
   assign data_bus.data_wdata_o = wdata_reg;

   assign lsu_err_o       = (state_reg == DONE) && err_reg;
   assign lsu_data_o      = lsu_err_o ? 32'h0 : rdata_reg;
   assign lsu_stall_req_o = lsu_req_i && (state_reg != DONE);

endmodule

// File: doc/miriscv_lsu.md
MIRISCV_LSU -- requirements
Module: miriscv_lsu

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 clk_i  in  1  single clock, all state on rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 lsu_req_i  in  1  core requests a memory access; held with all lsu_* inputs while lsu_stall_req_o=1.
REQ-005 lsu_we_i  in  1  1=store, 0=load.
REQ-006 lsu_size_i  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
REQ-007 lsu_addr_i  in  32  byte address, driven by the ALU result.
REQ-008 lsu_data_i  in  32  store data, right-aligned.
REQ-009 lsu_data_o  out  32  load result, aligned and extended.
REQ-010 lsu_stall_req_o  out  1  core pipeline stall.
REQ-011 lsu_err_o  out  1  misaligned address or illegal size; one-cycle pulse.
REQ-012 data_req_o  out  1  memory request.
REQ-013 data_we_o  out  1  memory write enable.
REQ-014 data_be_o  out  4  byte enables.
REQ-015 data_addr_o  out  32  word-aligned address (addr[1:0]=00).
REQ-016 data_wdata_o  out  32  lane-replicated write data.
REQ-017 data_gnt_i  in  1  memory accepted request.
REQ-018 data_rvalid_i  in  1  read data valid.
REQ-019 data_rdata_i  in  32  read data word.

Function
REQ-020 FSM states IDLE, REQ, WAIT, DONE; inputs sampled only in IDLE.
REQ-021 IDLE: lsu_req_i=1 and access legal -> REQ, registering addr, be, wdata, we, size, addr[1:0]. Access illegal -> DONE with error flag.
REQ-022 Illegal access: H/HU with addr[0]=1; W with addr[1:0]!=00; size 011, 110, 111; store with size 1xx. No memory request is issued.
REQ-023 REQ: data_req_o=1. On data_gnt_i=1: a store goes to DONE and a load goes to WAIT. Otherwise stay in REQ with outputs stable.
REQ-024 WAIT: data_req_o=0. On data_rvalid_i=1, go to DONE and capture the extracted load data. data_rvalid_i is ignored in every other state.
REQ-025 DONE: lasts exactly one cycle and returns to IDLE.
REQ-026 lsu_err_o=1 only in DONE reached via an illegal access. lsu_data_o=0 in that case.
REQ-027 lsu_stall_req_o = lsu_req_i AND state!=DONE (combinational).
REQ-028 Minimum load latency with gnt in the first REQ cycle and rvalid the next cycle: IDLE, REQ, WAIT, DONE. The stall is high for 3 cycles.
REQ-029 Minimum store latency: IDLE, REQ, DONE. The stall is high for 2 cycles.
REQ-030 Byte enables: B -> 0001<<addr[1:0]; H -> 0011<<addr[1:0]; W -> 1111.
REQ-031 Write data: B -> data[7:0] in all 4 lanes; H -> data[15:0] in both halves; W -> data unchanged.
REQ-032 Load extraction: lane = rdata >> (8*addr[1:0]). B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
REQ-033 lsu_data_o holds the last captured load value until the next load completes. Stores and errors do not change it, except that an error drives it to 0 during DONE only.
REQ-034 If lsu_req_i drops in REQ or WAIT, the transaction is not aborted; it completes normally.
REQ-035 data_we_o, data_be_o, data_addr_o and data_wdata_o are registered and stable from REQ entry until leaving REQ.

Reset
REQ-036 rst_i=1 at a clock edge: state goes to IDLE. lsu_data_o, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o and lsu_err_o go to 0.
REQ-037 Reset in REQ or WAIT abandons the transaction. data_req_o is 0 from the cycle after the reset edge. A late rvalid is ignored.
REQ-038 Reset has priority over all FSM transitions.

Verification
REQ-039 LW addr=0x100, gnt same cycle, rdata=0xDEADBEEF next cycle -> data_addr_o=0x100, be=1111, lsu_data_o=0xDEADBEEF, stall high 3 cycles.
REQ-040 LB/LBU addr=0x103, rdata=0x80FF0000 -> LB gives 0xFFFFFF80; LBU gives 0x00000080; data_addr_o=0x100.
REQ-041 SH addr=0x202, data=0x1234ABCD, gnt delayed 3 cycles -> be=1100, wdata=0xABCDABCD, req held 4 cycles, no WAIT state.
REQ-042 LW addr=0x101 -> data_req_o never asserted, lsu_err_o pulses 1 cycle, stall high 1 cycle.
REQ-043 rst_i asserted during WAIT, then rvalid -> data_req_o=0, FSM in IDLE, lsu_data_o=0.
REQ-044 Back-to-back LH 0x002 (rdata=0x8001xxxx -> 0xFFFF8001) then SW 0x004 -> second request starts in the cycle after DONE; lsu_data_o holds 0xFFFF8001 through the store.
